mem_port_arbiter: RTL and testbench

- Shares one single-port SRAM-like memory between the CPU instruction-fetch port and the data (load/store) port.
- Sits between the pipeline's fetch/memory stages and the unified memory, replacing the separate inst_sram/data_sram hookup.
- Arbitrates requests, issues one access at a time, tracks fixed memory read latency, and buffers read data until the owning requester accepts it.

---
 rtl/cpu_mem_pkg.sv | 16 +
 rtl/mem_resp_buf.sv | 26 ++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the unified instruction/data memory port arbiter.
// Holds the arbiter state encoding, the owner ids and the read strobe value.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [3:0] WEN_READ = 4'b0000;

endpackage

// File: rtl/mem_resp_buf.sv
// One-entry read response buffer: holds a captured memory word and its valid
// flag until the owning pipeline stage acknowledges it.
module mem_resp_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        cap_en,
    input  logic [31:0] cap_data,
    input  logic        ack,
    output logic [31:0] rdata,
    output logic        rdata_valid
);

    // A capture always wins over a stale ack; an ack with nothing held is harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata       <= 32'h0;
            rdata_valid <= 1'b0;
        end else if (cap_en) begin
            rdata       <= cap_data;
            rdata_valid <= 1'b1;
        end else if (ack) begin
            rdata_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and load/store ports.
// Define ARB_AGE_EN to force-grant a starved fetch port after STARVE_MAX losses.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req_valid,
    input  logic [31:0] inst_req_addr,
    output logic        inst_req_ack,
    output logic [31:0] inst_rdata,
    output logic        inst_rdata_valid,
    input  logic        inst_rdata_ack,
    input  logic        data_req_valid,
    input  logic [31:0] data_req_addr,
    input  logic [3:0]  data_req_wen,
    input  logic [31:0] data_req_wdata,
    output logic        data_req_ack,
    output logic [31:0] data_rdata,
    output logic        data_rdata_valid,
    input  logic        data_rdata_ack,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [2:0] LAT_CNT    = 3'(MEM_LAT);
    localparam logic [2:0] STARVE_LIM = (STARVE_MAX < 1) ? 3'd1 : 3'(STARVE_MAX);

    arb_state_t state, state_nxt;
    logic [2:0] lat_cnt;
    logic       owner;
    logic [2:0] starve_cnt;
    logic       age_force;
    logic       inst_cap, data_cap;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lat_cnt <= 3'd0;
            owner   <= OWN_INST;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == WAIT) begin
                lat_cnt <= 3'd1;
                owner   <= data_req_ack ? OWN_DATA : OWN_INST;
            end else if (state == WAIT && lat_cnt != LAT_CNT) begin
                lat_cnt <= lat_cnt + 3'd1;
            end
        end
    end

`ifdef ARB_AGE_EN
    // Counts arbitrations the fetch port lost to the data port since its last grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 3'd0;
        end else if (inst_req_ack) begin
            starve_cnt <= 3'd0;
        end else if (inst_req_valid && data_req_ack && starve_cnt < STARVE_LIM) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end
`else
    assign starve_cnt = 3'd0;
`endif

    assign age_force = (starve_cnt >= STARVE_LIM);

    // Every combinational output is held at zero while reset is asserted.
    always_comb begin
        state_nxt    = state;
        inst_req_ack = 1'b0;
        data_req_ack = 1'b0;
        mem_en       = 1'b0;
        mem_addr     = 32'h0;
        mem_wen      = WEN_READ;
        mem_wdata    = 32'h0;
        inst_cap     = 1'b0;
        data_cap     = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (data_req_valid && !(inst_req_valid && age_force)) begin
                        data_req_ack = 1'b1;
                        mem_en       = 1'b1;
                        mem_addr     = data_req_addr;
                        mem_wen      = data_req_wen;
                        mem_wdata    = data_req_wdata;
                        if (data_req_wen == WEN_READ) begin
                            state_nxt = WAIT;
                        end
                    end else if (inst_req_valid) begin
                        inst_req_ack = 1'b1;
                        mem_en       = 1'b1;
                        mem_addr     = inst_req_addr;
                        state_nxt    = WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == LAT_CNT) begin
                        inst_cap  = (owner == OWN_INST);
                        data_cap  = (owner == OWN_DATA);
                        state_nxt = RESP;
                    end
                end
                RESP: begin
                    if (owner == OWN_DATA ? (data_rdata_valid && data_rdata_ack)
                                          : (inst_rdata_valid && inst_rdata_ack)) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = !rst && (state != IDLE);

    mem_resp_buf u_inst_buf (
        .clk         (clk),
        .rst         (rst),
        .cap_en      (inst_cap),
        .cap_data    (mem_rdata),
        .ack         (inst_rdata_ack),
        .rdata       (inst_rdata),
        .rdata_valid (inst_rdata_valid)
    );

    mem_resp_buf u_data_buf (
        .clk         (clk),
        .rst         (rst),
        .cap_en      (data_cap),
        .cap_data    (mem_rdata),
        .ack         (data_rdata_ack),
        .rdata       (data_rdata),
        .rdata_valid (data_rdata_valid)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1 and one with
// MEM_LAT=3 share stimulus; expectations follow ARB_AGE_EN when it is defined.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        rst;
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic [3:0]  dw;
        logic [31:0] dd;
        logic        irack;
        logic        drack;
    } in_t;

    typedef struct packed {
        logic        iack;
        logic        dack;
        logic        men;
        logic [31:0] maddr;
        logic [3:0]  mwen;
        logic [31:0] mwd;
        logic        busy;
        logic        ivld;
        logic        dvld;
        logic [31:0] ird;
        logic [31:0] drd;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    localparam logic [31:0] BFC = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        rst, inst_req_valid, data_req_valid, inst_rdata_ack, data_rdata_ack;
    logic [31:0] inst_req_addr, data_req_addr, data_req_wdata;
    logic [3:0]  data_req_wen;

    logic        inst_req_ack_1, inst_rdata_valid_1, data_req_ack_1, data_rdata_valid_1;
    logic        mem_en_1, busy_1;
    logic [31:0] inst_rdata_1, data_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
    logic [3:0]  mem_wen_1;

    logic        inst_req_ack_3, inst_rdata_valid_3, data_req_ack_3, data_rdata_valid_3;
    logic        mem_en_3, busy_3;
    logic [31:0] inst_rdata_3, data_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;
    logic [3:0]  mem_wen_3;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk(clk), .rst(rst),
        .inst_req_valid(inst_req_valid), .inst_req_addr(inst_req_addr),
        .inst_req_ack(inst_req_ack_1), .inst_rdata(inst_rdata_1),
        .inst_rdata_valid(inst_rdata_valid_1), .inst_rdata_ack(inst_rdata_ack),
        .data_req_valid(data_req_valid), .data_req_addr(data_req_addr),
        .data_req_wen(data_req_wen), .data_req_wdata(data_req_wdata),
        .data_req_ack(data_req_ack_1), .data_rdata(data_rdata_1),
        .data_rdata_valid(data_rdata_valid_1), .data_rdata_ack(data_rdata_ack),
        .mem_en(mem_en_1), .mem_addr(mem_addr_1), .mem_wen(mem_wen_1),
        .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1), .busy(busy_1)
    );

    mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .rst(rst),
        .inst_req_valid(inst_req_valid), .inst_req_addr(inst_req_addr),
        .inst_req_ack(inst_req_ack_3), .inst_rdata(inst_rdata_3),
        .inst_rdata_valid(inst_rdata_valid_3), .inst_rdata_ack(inst_rdata_ack),
        .data_req_valid(data_req_valid), .data_req_addr(data_req_addr),
        .data_req_wen(data_req_wen), .data_req_wdata(data_req_wdata),
        .data_req_ack(data_req_ack_3), .data_rdata(data_rdata_3),
        .data_rdata_valid(data_rdata_valid_3), .data_rdata_ack(data_rdata_ack),
        .mem_en(mem_en_3), .mem_addr(mem_addr_3), .mem_wen(mem_wen_3),
        .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3), .busy(busy_3)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a == BFC) ? 32'h24080001 : (a ^ 32'h5a5a0000);
    endfunction

    // Memory model: read data is valid only in the exact latency cycle after issue.
    logic [7:0]  iss_1 = 8'h0;
    logic [7:0]  iss_3 = 8'h0;
    logic [31:0] adr_1 [8];
    logic [31:0] adr_3 [8];

    always @(posedge clk) begin
        iss_1    <= {iss_1[6:0], (mem_en_1 && (mem_wen_1 == 4'b0000))};
        iss_3    <= {iss_3[6:0], (mem_en_3 && (mem_wen_3 == 4'b0000))};
        adr_1[0] <= mem_addr_1;
        adr_3[0] <= mem_addr_3;
        for (int k = 1; k < 8; k++) begin
            adr_1[k] <= adr_1[k-1];
            adr_3[k] <= adr_3[k-1];
        end
    end

    assign mem_rdata_1 = iss_1[0] ? word(adr_1[0]) : 32'hdeadbeef;
    assign mem_rdata_3 = iss_3[2] ? word(adr_3[2]) : 32'hdeadbeef;

    function automatic in_t mki(input logic r, input logic iv, input logic [31:0] ia,
                                input logic dv, input logic [31:0] da, input logic [3:0] dw,
                                input logic [31:0] dd, input logic irack, input logic drack);
        return '{r, iv, ia, dv, da, dw, dd, irack, drack};
    endfunction

    function automatic out_t mko(input logic iack, input logic dack, input logic men,
                                 input logic [31:0] maddr, input logic [3:0] mwen,
                                 input logic [31:0] mwd, input logic bsy, input logic ivld,
                                 input logic dvld, input logic [31:0] ird, input logic [31:0] drd);
        return '{iack, dack, men, maddr, mwen, mwd, bsy, ivld, dvld, ird, drd};
    endfunction

    // Read data is only meaningful while its valid flag is up.
    function automatic out_t get_out1();
        return '{inst_req_ack_1, data_req_ack_1, mem_en_1, mem_addr_1, mem_wen_1, mem_wdata_1,
                 busy_1, inst_rdata_valid_1, data_rdata_valid_1,
                 inst_rdata_valid_1 ? inst_rdata_1 : 32'h0,
                 data_rdata_valid_1 ? data_rdata_1 : 32'h0};
    endfunction

    function automatic out_t get_out3();
        return '{inst_req_ack_3, data_req_ack_3, mem_en_3, mem_addr_3, mem_wen_3, mem_wdata_3,
                 busy_3, inst_rdata_valid_3, data_rdata_valid_3,
                 inst_rdata_valid_3 ? inst_rdata_3 : 32'h0,
                 data_rdata_valid_3 ? data_rdata_3 : 32'h0};
    endfunction

    task automatic applyStimulus(input in_t s);
        rst            = s.rst;
        inst_req_valid = s.iv;
        inst_req_addr  = s.ia;
        data_req_valid = s.dv;
        data_req_addr  = s.da;
        data_req_wen   = s.dw;
        data_req_wdata = s.dd;
        inst_rdata_ack = s.irack;
        data_rdata_ack = s.drack;
    endtask

    task automatic checkOutput(input string name, input out_t act, input out_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive just after the rising edge, sample on the falling edge.
    task automatic step(input in_t s);
        @(posedge clk);
        #1;
        applyStimulus(s);
        @(negedge clk);
    endtask

    vec_t vecs[$];
    out_t z;
    in_t  idle;

    initial begin
        z    = mko(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle = mki(0, 0, 0, 0, 0, 0, 0, 0, 0);

        vecs.push_back('{mki(1, 1, BFC, 0, 0, 0, 0, 0, 0), z});
        vecs.push_back('{mki(0, 1, BFC, 0, 0, 0, 0, 0, 0), mko(1, 0, 1, BFC, 0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{idle, mko(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{mki(0, 1, 'h100, 0, 0, 0, 0, 0, 0), mko(0, 0, 0, 0, 0, 0, 1, 1, 0, 'h24080001, 0)});
        vecs.push_back('{mki(0, 1, 'h100, 0, 0, 0, 0, 0, 0), mko(0, 0, 0, 0, 0, 0, 1, 1, 0, 'h24080001, 0)});
        vecs.push_back('{mki(0, 1, 'h100, 0, 0, 0, 0, 1, 0), mko(0, 0, 0, 0, 0, 0, 1, 1, 0, 'h24080001, 0)});
        vecs.push_back('{mki(0, 1, 'h100, 1, 'h200, 0, 0, 0, 0), mko(0, 1, 1, 'h200, 0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{mki(0, 1, 'h100, 0, 0, 0, 0, 0, 0), mko(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{mki(0, 1, 'h100, 0, 0, 0, 0, 1, 0), mko(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, word('h200))});
        vecs.push_back('{mki(0, 1, 'h100, 0, 0, 0, 0, 0, 1), mko(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, word('h200))});
        vecs.push_back('{mki(0, 1, 'h100, 0, 0, 0, 0, 0, 0), mko(1, 0, 1, 'h100, 0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{idle, mko(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{mki(0, 0, 0, 0, 0, 0, 0, 1, 0), mko(0, 0, 0, 0, 0, 0, 1, 1, 0, word('h100), 0)});
        vecs.push_back('{mki(0, 0, 0, 1, 'h10, 'hf, 'h11111111, 0, 0), mko(0, 1, 1, 'h10, 'hf, 'h11111111, 0, 0, 0, 0, 0)});
        vecs.push_back('{mki(0, 0, 0, 1, 'h14, 'hf, 'h22222222, 0, 0), mko(0, 1, 1, 'h14, 'hf, 'h22222222, 0, 0, 0, 0, 0)});
        vecs.push_back('{mki(0, 0, 0, 1, 'h18, 'hf, 'h33333333, 0, 0), mko(0, 1, 1, 'h18, 'hf, 'h33333333, 0, 0, 0, 0, 0)});
        vecs.push_back('{idle, z});
        vecs.push_back('{mki(0, 0, 0, 1, 'h300, 0, 0, 0, 0), mko(0, 1, 1, 'h300, 0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{mki(1, 0, 0, 0, 0, 0, 0, 0, 0), z});
        vecs.push_back('{idle, z});
        vecs.push_back('{idle, z});
        vecs.push_back('{mki(0, 0, 0, 1, 'h40, 'h3, 'habcd1234, 0, 0), mko(0, 1, 1, 'h40, 'h3, 'habcd1234, 0, 0, 0, 0, 0)});
        vecs.push_back('{idle, z});
        vecs.push_back('{mki(0, 1, 'h44, 1, 'h48, 'hf, 'h55, 0, 0), mko(0, 1, 1, 'h48, 'hf, 'h55, 0, 0, 0, 0, 0)});
        vecs.push_back('{mki(0, 1, 'h44, 0, 0, 0, 0, 0, 0), mko(1, 0, 1, 'h44, 0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{idle, mko(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{mki(0, 0, 0, 0, 0, 0, 0, 1, 0), mko(0, 0, 0, 0, 0, 0, 1, 1, 0, word('h44), 0)});
        vecs.push_back('{idle, z});

        applyStimulus(mki(1, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);

        $display("[TB] table vectors on MEM_LAT=1 instance");
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].i);
            checkOutput($sformatf("vec%0d", i), get_out1(), vecs[i].o);
        end

        $display("[TB] MEM_LAT=3 read with delayed response ack");
        step(mki(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mki(0, 0, 0, 1, 'h200, 0, 0, 0, 0));
        checkOutput("lat3_issue", get_out3(), mko(0, 1, 1, 'h200, 0, 0, 0, 0, 0, 0, 0));
        for (int c = 1; c <= 3; c++) begin
            step(idle);
            checkOutput($sformatf("lat3_wait%0d", c), get_out3(), mko(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        end
        for (int c = 4; c <= 9; c++) begin
            step(mki(0, 0, 0, 1, 'h204, 0, 0, 0, (c == 9)));
            checkOutput($sformatf("lat3_resp%0d", c), get_out3(),
                        mko(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, word('h200)));
        end
        step(mki(0, 0, 0, 1, 'h204, 0, 0, 0, 0));
        checkOutput("lat3_next_issue", get_out3(), mko(0, 1, 1, 'h204, 0, 0, 0, 0, 0, 0, 0));

        $display("[TB] fetch competing with a continuous store stream");
        step(mki(1, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef ARB_AGE_EN
        for (int k = 0; k < 5; k++) begin
            step(mki(0, 1, 'h500, 1, 'h600 + 4 * k, 'hf, k, 0, 0));
            if (k == 4)
                checkOutput("age_force_grant", get_out1(), mko(1, 0, 1, 'h500, 0, 0, 0, 0, 0, 0, 0));
            else
                checkOutput($sformatf("age_store%0d", k), get_out1(),
                            mko(0, 1, 1, 'h600 + 4 * k, 'hf, k, 0, 0, 0, 0, 0));
        end
`else
        for (int k = 0; k < 8; k++) begin
            step(mki(0, 1, 'h500, 1, 'h600 + 4 * k, 'hf, k, 0, 0));
            checkOutput($sformatf("prio_store%0d", k), get_out1(),
                        mko(0, 1, 1, 'h600 + 4 * k, 'hf, k, 0, 0, 0, 0, 0));
        end
`endif
        step(idle);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
